// File: rtl/button_cmd_front_pkg.sv
// Shared constants for the button command front-end: command codes, button
// indices, output FSM states and the priority helper used by the arbiter.
package button_cmd_front_pkg;

  typedef enum logic [2:0] {
    CMD_NONE     = 3'd0,
    CMD_RIGHT    = 3'd1,
    CMD_LEFT     = 3'd2,
    CMD_DOWN     = 3'd3,
    CMD_UP       = 3'd4,
    CMD_DECISION = 3'd5,
    CMD_RED_RST  = 3'd6,
    CMD_BLUE_RST = 3'd7
  } cmd_e;

  localparam int BTN_RIGHT    = 0;
  localparam int BTN_LEFT     = 1;
  localparam int BTN_DOWN     = 2;
  localparam int BTN_UP       = 3;
  localparam int BTN_DECISION = 4;
  localparam int BTN_RED_RST  = 5;
  localparam int BTN_BLUE_RST = 6;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  // Index of the highest set bit; 0 when nothing is set.
  function automatic logic [2:0] hi_index(input logic [6:0] vec);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 7; i++) begin
      if (vec[i]) begin
        idx = 3'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/button_cmd_front_btn_debounce.sv
// One button: two-flop synchroniser followed by a tick-driven debounce
// counter that flips the level after DEB_CNT consecutive differing samples.
module btn_debounce #(
  parameter int DEB_CNT = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  input  logic tick,
  output logic level
);

  logic       sync1_r;
  logic       sync2_r;
  logic       level_r;
  logic [3:0] cnt_r;

  // Synchronise every clk; count differing samples only on tick.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      level_r <= 1'b0;
      cnt_r   <= 4'd0;
    end else begin
      sync1_r <= raw;
      sync2_r <= sync1_r;
      if (tick) begin
        if (sync2_r != level_r) begin
          if (cnt_r == 4'(DEB_CNT - 1)) begin
            level_r <= ~level_r;
            cnt_r   <= 4'd0;
          end else begin
            cnt_r <= cnt_r + 4'd1;
          end
        end else begin
          cnt_r <= 4'd0;
        end
      end
    end
  end

  assign level = level_r;

endmodule

// File: rtl/button_cmd_front.sv
// Button front-end: debounced press events plus direction auto-repeat are
// queued in a pending mask and handed out one at a time over valid/ack.
module button_cmd_front
  import button_cmd_front_pkg::*;
#(
  parameter int N_BTN       = 7,
  parameter int DEB_CNT     = 4,
  parameter int REPEAT_EN   = 1,
  parameter int REPEAT_DLY  = 8,
  parameter int REPEAT_RATE = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_BTN-1:0] bttns,
  input  logic             tick,
  input  logic             cmd_ack,
  output logic [2:0]       cmd_code,
  output logic             cmd_valid,
  output logic [N_BTN-1:0] bttns_level,
  output logic             overrun
);

  localparam int REP_MAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
  localparam int RW      = $clog2(REP_MAX + 1);

  logic [N_BTN-1:0] level_s;
  logic [N_BTN-1:0] level_q_r;
  logic [N_BTN-1:0] press_s;
  logic [N_BTN-1:0] rep_ev_s;
  logic [N_BTN-1:0] ev_s;
  logic [N_BTN-1:0] pending_r;
  logic [N_BTN-1:0] clr_s;
  logic [RW-1:0]    rep_tmr_r;
  logic [2:0]       rep_tgt_r;
  logic [2:0]       dir_idx_s;
  logic [2:0]       sel_s;
  logic             overrun_r;
  state_e           state_r;
  state_e           state_nxt_s;
  logic [2:0]       code_r;
  logic [2:0]       code_nxt_s;
  logic             valid_r;
  logic             valid_nxt_s;

  for (genvar g = 0; g < N_BTN; g++) begin : g_deb
    btn_debounce #(.DEB_CNT(DEB_CNT)) u_deb (
      .clk     (clk),
      .reset_n (reset_n),
      .raw     (bttns[g]),
      .tick    (tick),
      .level   (level_s[g])
    );
  end

  // Previous debounced level for rising-edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level_q_r <= '0;
    end else begin
      level_q_r <= level_s;
    end
  end

  assign press_s   = level_s & ~level_q_r;
  assign dir_idx_s = hi_index({3'b000, press_s[BTN_UP:BTN_RIGHT]});

  // Single repeat timer follows the latest direction press; 0 means idle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rep_tmr_r <= '0;
      rep_tgt_r <= 3'd0;
    end else if (REPEAT_EN == 0) begin
      rep_tmr_r <= '0;
      rep_tgt_r <= 3'd0;
    end else if (|press_s[BTN_UP:BTN_RIGHT]) begin
      rep_tgt_r <= dir_idx_s;
      rep_tmr_r <= RW'(REPEAT_DLY);
    end else if (!level_s[rep_tgt_r]) begin
      rep_tmr_r <= '0;
    end else if (tick && (rep_tmr_r != '0)) begin
      if (rep_tmr_r == RW'(1)) begin
        rep_tmr_r <= RW'(REPEAT_RATE);
      end else begin
        rep_tmr_r <= rep_tmr_r - RW'(1);
      end
    end
  end

  // Repeat event fires on the tick that expires the timer.
  always_comb begin
    rep_ev_s = '0;
    if ((REPEAT_EN != 0) && tick && (rep_tmr_r == RW'(1)) && level_s[rep_tgt_r]) begin
      rep_ev_s[rep_tgt_r] = 1'b1;
    end else begin
      rep_ev_s = '0;
    end
  end

  assign ev_s = press_s | rep_ev_s;

  // Pending mask: a new event beats a same-cycle clear; a repeat while pending is lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending_r <= '0;
      overrun_r <= 1'b0;
    end else begin
      pending_r <= (pending_r & ~clr_s) | ev_s;
      overrun_r <= overrun_r | (|(ev_s & pending_r & ~clr_s));
    end
  end

  assign sel_s = hi_index(pending_r);

  // Output FSM next state: pick highest pending in IDLE, hold until ack.
  always_comb begin
    state_nxt_s = state_r;
    code_nxt_s  = code_r;
    valid_nxt_s = valid_r;
    clr_s       = '0;
    case (state_r)
      IDLE: begin
        if (|pending_r) begin
          clr_s[sel_s] = 1'b1;
          code_nxt_s   = sel_s + 3'd1;
          valid_nxt_s  = 1'b1;
          state_nxt_s  = HOLD;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      HOLD: begin
        if (cmd_ack) begin
          code_nxt_s  = CMD_NONE;
          valid_nxt_s = 1'b0;
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = HOLD;
        end
      end
      default: begin
        code_nxt_s  = CMD_NONE;
        valid_nxt_s = 1'b0;
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Output FSM state and registered command outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
      code_r  <= CMD_NONE;
      valid_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      code_r  <= code_nxt_s;
      valid_r <= valid_nxt_s;
    end
  end

  assign cmd_code    = code_r;
  assign cmd_valid   = valid_r;
  assign bttns_level = level_s;
  assign overrun     = overrun_r;

endmodule

// File: tb/tb_button_cmd_front.sv
// Bench for button_cmd_front: directed scenarios plus random buttons/ticks/acks,
// compared every cycle against an event-level reference model.
module tb_button_cmd_front;

  localparam int DEB  = 4;
  localparam int DLY  = 8;
  localparam int RATE = 3;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [6:0] bttns;
  logic       tick;
  logic       cmd_ack;
  logic [2:0] cmd_code;
  logic       cmd_valid;
  logic [6:0] bttns_level;
  logic       overrun;

  always #5 clk = ~clk;

  button_cmd_front #(
    .N_BTN(7), .DEB_CNT(DEB), .REPEAT_EN(1), .REPEAT_DLY(DLY), .REPEAT_RATE(RATE)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .bttns       (bttns),
    .tick        (tick),
    .cmd_ack     (cmd_ack),
    .cmd_code    (cmd_code),
    .cmd_valid   (cmd_valid),
    .bttns_level (bttns_level),
    .overrun     (overrun)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model state
  logic [6:0] m_s1, m_s2, m_lvl, m_lvlq, m_pend;
  int         m_run [7];
  bit         m_act;
  int         m_tgt, m_k;
  logic [2:0] m_code;
  bit         m_valid, m_ovr;

  // Stimulus control
  int tick_mode = 0;
  int tick_cnt  = 0;
  int ack_dly   = 0;
  int held      = 0;
  bit rand_ack  = 0;
  int dut_log[$];

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_lvl = '0; m_lvlq = '0; m_pend = '0;
    for (int i = 0; i < 7; i++) m_run[i] = 0;
    m_act = 0; m_tgt = 0; m_k = 0;
    m_code = 3'd0; m_valid = 0; m_ovr = 0;
    held = 0;
  endtask

  task automatic model_update();
    logic [6:0] press, rep, ev, clr;
    int sel, kk;
    if (!reset_n) begin
      model_reset();
      return;
    end
    press = m_lvl & ~m_lvlq;
    rep   = '0;
    if (m_act && tick && m_lvl[m_tgt]) begin
      kk = m_k + 1;
      if (kk == DLY || (kk > DLY && (kk - DLY) % RATE == 0)) rep[m_tgt] = 1'b1;
    end
    if (|press[3:0]) begin
      m_act = 1; m_k = 0;
      for (int i = 0; i < 4; i++) if (press[i]) m_tgt = i;
    end else if (!m_lvl[m_tgt]) begin
      m_act = 0;
    end else if (tick) begin
      m_k++;
    end
    ev  = press | rep;
    clr = '0;
    sel = 0;
    if (!m_valid) begin
      if (m_pend != 7'd0) begin
        for (int i = 0; i < 7; i++) if (m_pend[i]) sel = i;
        clr[sel] = 1'b1;
        m_code   = 3'(sel + 1);
        m_valid  = 1;
      end
    end else if (cmd_ack) begin
      m_valid = 0;
      m_code  = 3'd0;
    end
    if (|(ev & m_pend & ~clr)) m_ovr = 1;
    m_pend = (m_pend & ~clr) | ev;
    m_lvlq = m_lvl;
    for (int i = 0; i < 7; i++) begin
      if (tick) begin
        if (m_s2[i] != m_lvl[i]) begin
          m_run[i]++;
          if (m_run[i] == DEB) begin
            m_lvl[i] = ~m_lvl[i];
            m_run[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
    end
    m_s2 = m_s1;
    m_s1 = bttns;
  endtask

  // One clock: drive at negedge, step model at posedge, compare at next negedge.
  task automatic cycle();
    if (tick_mode == 0) begin
      tick     = (tick_cnt == 0);
      tick_cnt = (tick_cnt + 1) % 4;
    end else begin
      tick = ($urandom % 3 == 0);
    end
    cmd_ack = m_valid && (held >= ack_dly);
    if (!m_valid && rand_ack) cmd_ack = 1'($urandom % 2);
    if (cmd_valid && cmd_ack) dut_log.push_back(int'(cmd_code));
    @(posedge clk);
    model_update();
    if (m_valid) held++; else held = 0;
    @(negedge clk);
    check("code",  32'(cmd_code),    32'(m_code));
    check("valid", 32'(cmd_valid),   32'(m_valid));
    check("level", 32'(bttns_level), 32'(m_lvl));
    check("ovr",   32'(overrun),     32'(m_ovr));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic hold(input logic [6:0] b, input int n);
    bttns = b;
    run(n);
  endtask

  initial begin
    reset_n = 1'b0; bttns = '0; tick = 1'b0; cmd_ack = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_code",  32'(cmd_code),    32'd0);
    check("rst_valid", 32'(cmd_valid),   32'd0);
    check("rst_level", 32'(bttns_level), 32'd0);
    check("rst_ovr",   32'(overrun),     32'd0);
    reset_n = 1'b1;
    run(8);

    // A: clean up press, 6 sampled ticks (below repeat delay)
    dut_log.delete(); ack_dly = 10;
    hold(7'b0001000, 24);
    hold(7'b0000000, 80);
    check("A_count", 32'(dut_log.size()), 32'd1);
    check("A_code",  32'(dut_log[0]),     32'd4);

    // B: up bouncing every 2 ticks for 12 ticks
    dut_log.delete();
    for (int i = 0; i < 3; i++) begin
      hold(7'b0001000, 8);
      hold(7'b0000000, 8);
    end
    run(40);
    check("B_count", 32'(dut_log.size()), 32'd0);
    check("B_ovr",   32'(overrun),        32'd0);

    // C: right and decision together, slow ack
    dut_log.delete(); ack_dly = 20;
    hold(7'b0010001, 24);
    hold(7'b0000000, 120);
    check("C_count", 32'(dut_log.size()), 32'd2);
    check("C_first", 32'(dut_log[0]),     32'd5);
    check("C_second", 32'(dut_log[1]),    32'd1);

    // R: left held for 21 sampled ticks with prompt acks -> press + 5 repeats
    dut_log.delete(); ack_dly = 1;
    hold(7'b0000010, 84);
    hold(7'b0000000, 80);
    check("R_count", 32'(dut_log.size()), 32'd6);
    for (int i = 0; i < 6; i++) check("R_code", 32'(dut_log[i]), 32'd2);

    // D: decision pressed twice while its first event waits behind blue reset
    dut_log.delete(); ack_dly = 100000;
    hold(7'b1000000, 60);
    hold(7'b1010000, 24);
    hold(7'b1000000, 40);
    hold(7'b1010000, 40);
    hold(7'b0000000, 40);
    check("D_ovr", 32'(overrun), 32'd1);
    ack_dly = 2;
    run(60);
    check("D_count", 32'(dut_log.size()), 32'd2);
    check("D_first", 32'(dut_log[0]),     32'd7);
    check("D_second", 32'(dut_log[1]),    32'd5);

    // E: reset pulse while blue reset command is held
    dut_log.delete(); ack_dly = 100000;
    hold(7'b1000000, 30);
    check("E_valid", 32'(cmd_valid), 32'd1);
    check("E_code",  32'(cmd_code),  32'd7);
    hold(7'b0000000, 40);
    #2 reset_n = 1'b0;
    #1;
    check("E_rst_valid", 32'(cmd_valid), 32'd0);
    check("E_rst_code",  32'(cmd_code),  32'd0);
    check("E_rst_ovr",   32'(overrun),   32'd0);
    model_reset();
    @(negedge clk);
    run(3);
    reset_n = 1'b1;
    run(60);
    check("E_count", 32'(dut_log.size()), 32'd0);

    // Random buttons, random tick spacing, random ack delays and idle acks
    tick_mode = 1; rand_ack = 1;
    for (int r = 0; r < 300; r++) begin
      bttns   = 7'($urandom) & ((($urandom % 4) == 0) ? 7'h7f : 7'h0f);
      ack_dly = (($urandom % 10) == 0) ? 40 : int'($urandom % 8);
      run($urandom_range(1, 40));
    end
    bttns = '0; ack_dly = 0;
    run(150);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
